// File: rtl/rb_pkg.sv
// Shared state type and default widths for the result readback engine.
package rb_pkg;

   localparam int RB_ADDR_W = 16;
   localparam int RB_DATA_W = 128;
   localparam int RB_LANE_W = 32;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_SEND,
      ST_FIN
   } rb_state_t;

endpackage

// File: rtl/lane_split.sv
// Combinational lane selector: picks one LANE_W slice of the holding register,
// lane 0 being the least significant slice.
module lane_split
   import rb_pkg::*;
#(
   parameter int DATA_W = RB_DATA_W,
   parameter int LANE_W = RB_LANE_W
) (
   input  logic [DATA_W-1:0] i_data,
   input  logic [1:0]        i_idx,
   output logic [LANE_W-1:0] o_lane
);

   always_comb begin
      case (i_idx)
         2'd0:    o_lane = i_data[LANE_W-1:0];
         2'd1:    o_lane = i_data[2*LANE_W-1:LANE_W];
         2'd2:    o_lane = i_data[3*LANE_W-1:2*LANE_W];
         default: o_lane = i_data[4*LANE_W-1:3*LANE_W];
      endcase
   end

endmodule

// File: rtl/result_readback.sv
// Reads count DATA_W entries from data memory and streams each as four LANE_W
// words with ready/valid handshake. Optional word_parity via RESULT_READBACK_PARITY_EN.
module result_readback
   import rb_pkg::*;
#(
   parameter int ADDR_W  = RB_ADDR_W,
   parameter int DATA_W  = RB_DATA_W,
   parameter int LANE_W  = RB_LANE_W,
   parameter int MEM_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] count,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rden,
   input  logic [DATA_W-1:0] mem_q,
   output logic [LANE_W-1:0] word_out,
   output logic              word_valid,
   input  logic              word_ready,
   output logic              word_last,
   output logic              busy,
   output logic              done
`ifdef RESULT_READBACK_PARITY_EN
   ,
   output logic              word_parity
`endif
);

   localparam logic [2:0]        LAT_LAST = 3'(MEM_LAT - 1);
   localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   rb_state_t         r_state;
   rb_state_t         w_next;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] r_remain;
   logic [2:0]        r_lat;
   logic [DATA_W-1:0] r_hold;
   logic [1:0]        r_lane;
   logic [LANE_W-1:0] w_lane;
   logic              w_accept;
   logic              w_lat_done;
   logic              w_lane_end;
   logic              w_last_entry;

   assign w_accept     = (r_state == ST_SEND) && word_ready;
   assign w_lat_done   = (r_lat == LAT_LAST);
   assign w_lane_end   = (r_lane == 2'd3);
   assign w_last_entry = (r_remain == ADDR_ONE);

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      if (!rst) r_state <= ST_IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      // NOTE: default assigned first so no path through the case infers a latch.
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (start) w_next = (count == '0) ? ST_FIN : ST_ISSUE;
         ST_ISSUE: w_next = ST_WAIT;
         ST_WAIT:  if (w_lat_done) w_next = ST_SEND;
         ST_SEND:  if (w_accept && w_lane_end) w_next = w_last_entry ? ST_FIN : ST_ISSUE;
         ST_FIN:   w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   // r_remain counts entries still owed, including the one in flight.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_addr   <= '0;
         r_remain <= '0;
         r_lat    <= '0;
         r_hold   <= '0;
         r_lane   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: if (start) begin
               r_addr   <= base_addr;
               r_remain <= count;
            end
            ST_ISSUE: r_lat <= '0;
            ST_WAIT: begin
               r_lat <= r_lat + 3'd1;
               if (w_lat_done) begin
                  r_hold <= mem_q;
                  r_lane <= '0;
               end
            end
            ST_SEND: if (w_accept) begin
               r_lane <= r_lane + 2'd1;
               if (w_lane_end) begin
                  r_addr   <= r_addr + ADDR_ONE;
                  r_remain <= r_remain - ADDR_ONE;
               end
            end
            default: ;
         endcase
      end
   end

   lane_split #(
      .DATA_W (DATA_W),
      .LANE_W (LANE_W)
   ) u_lane_split (
      .i_data (r_hold),
      .i_idx  (r_lane),
      .o_lane (w_lane)
   );

   assign mem_addr   = r_addr;
   assign mem_rden   = (r_state == ST_ISSUE);
   assign word_valid = (r_state == ST_SEND);
   assign word_out   = word_valid ? w_lane : '0;
   assign word_last  = word_valid && w_lane_end && w_last_entry;
   assign busy       = (r_state != ST_IDLE);
   assign done       = (r_state == ST_FIN);

`ifdef RESULT_READBACK_PARITY_EN
   assign word_parity = word_valid & (^word_out);
`endif

endmodule

// File: tb/tb_result_readback.sv
// Self-checking bench for result_readback: directed scenarios plus randomized
// runs against a queue-based model of the expected address and word streams.
module tb_result_readback;

   localparam int ADDR_W  = 16;
   localparam int DATA_W  = 128;
   localparam int LANE_W  = 32;
   localparam int MEM_LAT = 2;
   localparam int BUDGET  = 2000;

   logic              clk;
   logic              rst;
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [ADDR_W-1:0] count;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rden;
   logic [DATA_W-1:0] mem_q;
   logic [LANE_W-1:0] word_out;
   logic              word_valid;
   logic              word_ready;
   logic              word_last;
   logic              busy;
   logic              done;
`ifdef RESULT_READBACK_PARITY_EN
   logic              word_parity;
`endif

   int n_cmp = 0;
   int n_err = 0;

   logic [DATA_W-1:0] mem_over [int];
   logic [DATA_W-1:0] pipe [MEM_LAT];

   result_readback #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .LANE_W  (LANE_W),
      .MEM_LAT (MEM_LAT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .base_addr  (base_addr),
      .count      (count),
      .mem_addr   (mem_addr),
      .mem_rden   (mem_rden),
      .mem_q      (mem_q),
      .word_out   (word_out),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .word_last  (word_last),
      .busy       (busy),
      .done       (done)
`ifdef RESULT_READBACK_PARITY_EN
      ,
      .word_parity (word_parity)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DATA_W-1:0] mem_word(input int a);
      logic [DATA_W-1:0] w;
      if (mem_over.exists(a)) return mem_over[a];
      for (int l = 0; l < 4; l++)
         w[l*LANE_W +: LANE_W] = 32'(a * 32'h9E3779B1 + (l + 1) * 32'h7F4A7C15);
      return w;
   endfunction

   // Memory model: data for a read appears MEM_LAT edges after the rden cycle;
   // non-read cycles push junk so a mistimed capture is visible.
   always @(posedge clk) begin
      pipe[0] <= mem_rden ? mem_word(int'(mem_addr)) : {$urandom, $urandom, $urandom, $urandom};
      for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign mem_q = pipe[MEM_LAT-1];

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expd);
      n_cmp++;
      assert (obs === expd) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expd);
      end
   endtask

   // One readback: model computes addresses and lane words, consumer applies ready
   // (ready_pct percent, optional 3-cycle stall on the first lane stall_lane).
   task automatic run_rb(input string tag, input logic [15:0] base, input logic [15:0] cnt,
                         input int ready_pct, input bit junk_start, input int stall_lane);
      logic [15:0]  addr_q [$];
      logic [31:0]  exp_q  [$];
      logic [15:0]  a;
      logic [127:0] w;
      logic [127:0] exp_w;
      logic [16:0]  exp_a;
      int first_rden, first_valid, last_acc, done_cyc, accepted, stall_left, exp_last;

      for (int e = 0; e < int'(cnt); e++) begin
         a = base + 16'(e);
         addr_q.push_back(a);
         w = mem_word(int'(a));
         for (int l = 0; l < 4; l++) exp_q.push_back(w[l*32 +: 32]);
      end
      first_rden = -1; first_valid = -1; last_acc = -1; done_cyc = -1;
      accepted = 0; stall_left = 3;

      @(negedge clk);
      start = 1'b1; base_addr = base; count = cnt;
      for (int cyc = 1; cyc <= BUDGET; cyc++) begin
         @(negedge clk);
         if (junk_start) begin
            start = 1'($urandom_range(0, 1)); base_addr = 16'($urandom); count = 16'($urandom);
         end else start = 1'b0;
         check({tag, "_busy"}, busy, 1'b1);
         if (mem_rden) begin
            if (first_rden < 0) first_rden = cyc;
            exp_a = (addr_q.size() != 0) ? {1'b0, addr_q.pop_front()} : 17'h1_0000;
            check({tag, "_rden_addr"}, {1'b0, mem_addr}, exp_a);
         end
         if (word_valid) begin
            if (first_valid < 0) first_valid = cyc;
            exp_w = (exp_q.size() != 0) ? {96'b0, exp_q[0]} : {128{1'b1}};
            check({tag, "_word"}, word_out, exp_w);
            check({tag, "_last"}, word_last, exp_q.size() == 1);
`ifdef RESULT_READBACK_PARITY_EN
            check({tag, "_parity"}, word_parity, ^exp_w[31:0]);
`endif
            if (stall_lane >= 0 && stall_left > 0 && (accepted % 4) == stall_lane) begin
               word_ready = 1'b0; stall_left--;
            end else word_ready = ($urandom_range(0, 99) < ready_pct);
            if (word_ready && exp_q.size() != 0) begin
               void'(exp_q.pop_front());
               accepted++;
               if (exp_q.size() == 0) last_acc = cyc;
            end
         end else begin
            word_ready = 1'($urandom_range(0, 1));
            check({tag, "_last_idle"}, word_last, 1'b0);
         end
         if (done) begin
            done_cyc = cyc;
            if (junk_start) start = 1'b1;
            break;
         end
      end

      check({tag, "_done_seen"}, done_cyc > 0, 1'b1);
      check({tag, "_words_left"}, exp_q.size(), 0);
      check({tag, "_reads_left"}, addr_q.size(), 0);
      check({tag, "_first_rden"}, first_rden, (cnt != 0) ? 1 : -1);
      check({tag, "_first_valid"}, first_valid, (cnt != 0) ? MEM_LAT + 2 : -1);
      check({tag, "_done_cycle"}, done_cyc, (cnt != 0) ? last_acc + 1 : 1);
      if (ready_pct == 100 && cnt != 0) begin
         exp_last = MEM_LAT + 2 + 4 * int'(cnt) - 1 + (int'(cnt) - 1) * (MEM_LAT + 1)
                    + ((stall_lane >= 0) ? 3 : 0);
         check({tag, "_last_cycle"}, last_acc, exp_last);
      end
      @(negedge clk);
      start = 1'b0;
      check({tag, "_idle_busy"}, busy, 1'b0);
      check({tag, "_done_pulse"}, done, 1'b0);
      check({tag, "_idle_rden"}, mem_rden, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; start = 1'b0; base_addr = '0; count = '0; word_ready = 1'b0;
      mem_over[0]      = 128'h44444444_33333333_22222222_11111111;
      mem_over[16'h0100] = 128'h0000000F_00000001_00000003_00000007;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_mem_addr", mem_addr, 16'h0);
      check("rst_mem_rden", mem_rden, 1'b0);
      check("rst_word_out", word_out, 32'h0);
      check("rst_word_valid", word_valid, 1'b0);
      check("rst_word_last", word_last, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      rst = 1'b1;

      // Single entry, full-rate consumer
      run_rb("single", 16'h0000, 16'd1, 100, 1'b0, -1);
      // Back-pressure on lane 2
      run_rb("bp", 16'h0020, 16'd2, 100, 1'b0, 2);
      // Address wrap
      run_rb("wrap", 16'hFFFF, 16'd2, 100, 1'b0, -1);
      // Zero count, also with start pulsed during FIN
      run_rb("cnt0", 16'h1234, 16'd0, 100, 1'b0, -1);
      run_rb("cnt0_fin", 16'h4321, 16'd0, 100, 1'b1, -1);

      // Reset during WAIT of the first entry
      @(negedge clk);
      start = 1'b1; base_addr = 16'h0100; count = 16'd3;
      @(negedge clk);
      start = 1'b0;
      check("mid_issue_rden", mem_rden, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("mid_rst_mem_addr", mem_addr, 16'h0);
      check("mid_rst_mem_rden", mem_rden, 1'b0);
      check("mid_rst_word_out", word_out, 32'h0);
      check("mid_rst_word_valid", word_valid, 1'b0);
      check("mid_rst_word_last", word_last, 1'b0);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_done", done, 1'b0);
      rst = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("post_rst_done", done, 1'b0);
         check("post_rst_valid", word_valid, 1'b0);
         check("post_rst_busy", busy, 1'b0);
      end
      run_rb("post_rst", 16'h0100, 16'd1, 100, 1'b0, -1);

      // Randomized runs with random back-pressure and stray start pulses
      for (int r = 0; r < 5; r++)
         run_rb($sformatf("rand%0d", r), 16'($urandom), 16'($urandom_range(1, 4)), 60, 1'b1, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
